// File: rtl/ping_sequencer_pkg.sv
// ping_sequencer_pkg
// Shared definitions for the DVL ping sequencer: h-bridge mode encodings,
// sequencer state encoding, the default carrier divider and the latched
// phase-length bundle.
package ping_sequencer_pkg;

  // h-bridge driver mode bus encodings
  localparam logic [1:0] HB_HIGHZ = 2'b00;
  localparam logic [1:0] HB_DAMP  = 2'b01;
  localparam logic [1:0] HB_OSCL  = 2'b10;

  // 48 MHz system clock / 0.75 MHz carrier
  localparam int CARRIER_DIV = 64;

  typedef enum logic [2:0] {
    PS_IDLE   = 3'd0,
    PS_TX     = 3'd1,
    PS_DAMP   = 3'd2,
    PS_BLANK  = 3'd3,
    PS_LISTEN = 3'd4
  } ps_state_t;

  // Phase lengths as captured when a ping starts
  typedef struct packed {
    logic [15:0] burst;
    logic [15:0] damp;
    logic [15:0] blank;
    logic [15:0] listen;
  } ps_lens_t;

  // Mode driven onto the h-bridge bus while in a given state
  function automatic logic [1:0] hb_of(input ps_state_t s);
    logic [1:0] m;
    m = HB_HIGHZ;
    if (s == PS_TX)   m = HB_OSCL;
    if (s == PS_DAMP) m = HB_DAMP;
    return m;
  endfunction

endpackage

// File: rtl/ping_sequencer_phase_timer.sv
// phase_timer
// Loadable down-counter that times every phase of a ping. It stops at zero
// and holds there until the next load.
// Ports:
//   clk   - system clock
//   rst   - synchronous active-low reset (counter clears to 0)
//   load  - load value this cycle (takes priority over counting)
//   value - count to load (phase length - 1)
//   zero  - counter currently reads 0
module phase_timer
  import ping_sequencer_pkg::*;
#(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= value;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign zero = (r_cnt == '0);

endmodule

// File: rtl/ping_sequencer.sv
// ping_sequencer
// Transmit/receive timing controller for one DVL ping:
// IDLE -> TX (carrier burst) -> DAMP -> BLANK -> LISTEN -> IDLE.
// Ports:
//   clk, rst                     - 48 MHz clock, synchronous active-low reset
//   start                        - one-cycle ping request (ignored while busy)
//   abort                        - terminates the ping safely
//   burst_len                    - TX length in carrier periods
//   damp_len/blank_len/listen_len- phase lengths in clk cycles
//   hb_state                     - h-bridge mode bus
//   busy                         - high outside IDLE
//   rx_en                        - receive front-end enable (LISTEN only)
//   done                         - pulse on normal return to IDLE
//   aborted                      - pulse on return to IDLE after an abort
module ping_sequencer
  import ping_sequencer_pkg::*;
#(
  parameter int CNT_W       = 24,
  parameter int CARRIER_DIV = ping_sequencer_pkg::CARRIER_DIV
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] burst_len,
  input  logic [15:0] damp_len,
  input  logic [15:0] blank_len,
  input  logic [15:0] listen_len,
  output logic [1:0]  hb_state,
  output logic        busy,
  output logic        rx_en,
  output logic        done,
  output logic        aborted
);

  ps_state_t        r_state;
  ps_state_t        w_next;
  ps_lens_t         r_lens;
  ps_lens_t         w_in_lens;
  ps_lens_t         w_lens;
  logic             r_abort_pend;
  logic             w_pend_set;
  logic             w_adv;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_zero;
  logic             w_done_n;
  logic             w_abort_n;
  logic [1:0]       w_hb_n;
  logic             w_busy_n;
  logic             w_rx_n;
  logic [1:0]       r_hb;
  logic             r_busy;
  logic             r_rx_en;
  logic             r_done;
  logic             r_aborted;

  // Length of a phase in clk cycles
  function automatic logic [CNT_W-1:0] phase_len(input ps_state_t s, input ps_lens_t l);
    logic [CNT_W-1:0] n;
    n = '0;
    case (s)
      PS_TX:     n = CNT_W'(l.burst) * CNT_W'(CARRIER_DIV);
      PS_DAMP:   n = CNT_W'(l.damp);
      PS_BLANK:  n = CNT_W'(l.blank);
      PS_LISTEN: n = CNT_W'(l.listen);
      default:   n = '0;
    endcase
    return n;
  endfunction

  // First phase after s whose length is non-zero; IDLE when none remain
  function automatic ps_state_t next_phase(input ps_state_t s, input ps_lens_t l);
    ps_state_t n;
    n = PS_IDLE;
    if      (s == PS_IDLE && l.burst != '0)                         n = PS_TX;
    else if ((s == PS_IDLE || s == PS_TX) && l.damp != '0)          n = PS_DAMP;
    else if ((s == PS_IDLE || s == PS_TX || s == PS_DAMP) &&
             l.blank != '0)                                         n = PS_BLANK;
    else if (s != PS_LISTEN && l.listen != '0)                      n = PS_LISTEN;
    return n;
  endfunction

  assign w_in_lens = '{burst: burst_len, damp: damp_len, blank: blank_len, listen: listen_len};
  // In IDLE the ping about to start is judged on the live inputs, since the
  // shadow registers only capture them on this same edge.
  assign w_lens    = (r_state == PS_IDLE) ? w_in_lens : r_lens;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (w_load),
    .value (w_load_val),
    .zero  (w_zero)
  );

  assign w_load     = w_adv && (w_next != PS_IDLE);
  assign w_load_val = phase_len(w_next, w_lens) - CNT_W'(1);

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= PS_IDLE;
      r_abort_pend <= 1'b0;
      r_hb         <= HB_HIGHZ;
      r_busy       <= 1'b0;
      r_rx_en      <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_abort_pend <= (w_next == PS_IDLE) ? 1'b0 : (r_abort_pend | w_pend_set);
      r_hb         <= w_hb_n;
      r_busy       <= w_busy_n;
      r_rx_en      <= w_rx_n;
      r_done       <= w_done_n;
      r_aborted    <= w_abort_n;
    end
  end

  // Shadow lengths: captured on every start seen in IDLE
  always_ff @(posedge clk) begin
    if (r_state == PS_IDLE && start) begin
      r_lens <= w_in_lens;
    end
  end

  // Next-state logic; abort has priority over normal advance
  always_comb begin
    w_next     = r_state;
    w_adv      = 1'b0;
    w_pend_set = 1'b0;
    w_done_n   = 1'b0;
    w_abort_n  = 1'b0;
    unique case (r_state)
      PS_IDLE: begin
        if (start && !abort) begin
          w_adv    = 1'b1;
          w_next   = next_phase(PS_IDLE, w_lens);
          w_done_n = (w_next == PS_IDLE);
        end
      end
      PS_TX: begin
        if (abort) begin
          // Never leave the transducer ringing: damp first if a damping time exists
          w_adv = 1'b1;
          if (r_lens.damp != '0) begin
            w_next     = PS_DAMP;
            w_pend_set = 1'b1;
          end else begin
            w_next    = PS_IDLE;
            w_abort_n = 1'b1;
          end
        end else if (w_zero) begin
          w_adv    = 1'b1;
          w_next   = next_phase(PS_TX, r_lens);
          w_done_n = (w_next == PS_IDLE);
        end
      end
      PS_DAMP: begin
        // An abort here only takes effect once damping has completed
        if (w_zero) begin
          w_adv = 1'b1;
          if (r_abort_pend || abort) begin
            w_next    = PS_IDLE;
            w_abort_n = 1'b1;
          end else begin
            w_next   = next_phase(PS_DAMP, r_lens);
            w_done_n = (w_next == PS_IDLE);
          end
        end else if (abort) begin
          w_pend_set = 1'b1;
        end
      end
      PS_BLANK, PS_LISTEN: begin
        if (abort) begin
          w_adv     = 1'b1;
          w_next    = PS_IDLE;
          w_abort_n = 1'b1;
        end else if (w_zero) begin
          w_adv    = 1'b1;
          w_next   = next_phase(r_state, r_lens);
          w_done_n = (w_next == PS_IDLE);
        end
      end
      default: begin
        w_next = PS_IDLE;
      end
    endcase
  end

  // Output decode of the upcoming state, registered above
  always_comb begin
    w_hb_n   = hb_of(w_next);
    w_busy_n = (w_next != PS_IDLE);
    w_rx_n   = (w_next == PS_LISTEN);
  end

  assign hb_state = r_hb;
  assign busy     = r_busy;
  assign rx_en    = r_rx_en;
  assign done     = r_done;
  assign aborted  = r_aborted;

endmodule

// File: tb/tb_ping_sequencer.sv
module tb_ping_sequencer;
  import ping_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] burst_len = '0;
  logic [15:0] damp_len = '0;
  logic [15:0] blank_len = '0;
  logic [15:0] listen_len = '0;
  logic [1:0]  hb_state;
  logic        busy;
  logic        rx_en;
  logic        done;
  logic        aborted;

  ping_sequencer #(.CNT_W(24), .CARRIER_DIV(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .burst_len  (burst_len),
    .damp_len   (damp_len),
    .blank_len  (blank_len),
    .listen_len (listen_len),
    .hb_state   (hb_state),
    .busy       (busy),
    .rx_en      (rx_en),
    .done       (done),
    .aborted    (aborted)
  );

  always #5 clk = ~clk;

  // Per-ping summary; cycle numbers are relative to the cycle start is driven in
  typedef struct {
    int n_osc;
    int f_osc;
    int n_damp;
    int f_damp;
    int n_rx;
    int f_rx;
    int n_busy;
    int end_t;
    int kind;   // 1 = done, 2 = aborted, 3 = both
  } rec_t;

  rec_t sb[$];
  rec_t m;
  int   t = 0;
  bit   mon_active = 1'b0;
  bit   start_acc = 1'b0;
  bit   kill = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic rec_t exp_normal(input int b, input int d, input int bl, input int l);
    rec_t e;
    int tx;
    tx       = b * 64;
    e.n_osc  = tx;
    e.f_osc  = (tx != 0) ? 1 : 0;
    e.n_damp = d;
    e.f_damp = (d != 0) ? 1 + tx : 0;
    e.n_rx   = l;
    e.f_rx   = (l != 0) ? 1 + tx + d + bl : 0;
    e.end_t  = 1 + tx + d + bl + l;
    e.n_busy = e.end_t - 1;
    e.kind   = 1;
    return e;
  endfunction

  function automatic rec_t exp_abort_tx(input int d, input int a);
    rec_t e;
    e.n_osc  = a;
    e.f_osc  = 1;
    e.n_damp = d;
    e.f_damp = (d != 0) ? a + 1 : 0;
    e.n_rx   = 0;
    e.f_rx   = 0;
    e.end_t  = a + 1 + d;
    e.n_busy = e.end_t - 1;
    e.kind   = 2;
    return e;
  endfunction

  task automatic finish_ping(input rec_t g);
    rec_t e;
    if (sb.size() == 0) begin
      check("unexpected_end", 1, 0);
      return;
    end
    e = sb.pop_front();
    check("osc_cycles",  g.n_osc,  e.n_osc);
    check("osc_first",   g.f_osc,  e.f_osc);
    check("damp_cycles", g.n_damp, e.n_damp);
    check("damp_first",  g.f_damp, e.f_damp);
    check("rx_cycles",   g.n_rx,   e.n_rx);
    check("rx_first",    g.f_rx,   e.f_rx);
    check("busy_cycles", g.n_busy, e.n_busy);
    check("end_cycle",   g.end_t,  e.end_t);
    check("end_kind",    g.kind,   e.kind);
  endtask

  // Monitor: samples on the falling edge, inputs change just after the rising edge
  always @(negedge clk) begin
    if (kill) begin
      mon_active = 1'b0;
      if (sb.size() != 0) void'(sb.pop_front());
    end else begin
      if (mon_active) begin
        t++;
        if (hb_state == HB_OSCL) begin
          if (m.n_osc == 0) m.f_osc = t;
          m.n_osc++;
        end
        if (hb_state == HB_DAMP) begin
          if (m.n_damp == 0) m.f_damp = t;
          m.n_damp++;
        end
        if (rx_en === 1'b1) begin
          if (m.n_rx == 0) m.f_rx = t;
          m.n_rx++;
        end
        if (busy === 1'b1) m.n_busy++;
        if (done === 1'b1 || aborted === 1'b1) begin
          m.end_t = t;
          m.kind  = (aborted ? 2 : 0) + (done ? 1 : 0);
          finish_ping(m);
          mon_active = 1'b0;
        end
      end else if (done === 1'b1 || aborted === 1'b1) begin
        check("idle_pulse", 1, 0);
      end
      if (start_acc) begin
        mon_active = 1'b1;
        t = 0;
        m = '{default: 0};
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives an accepted start; returns in cycle 1 of the ping
  task automatic issue_start(input int b, input int d, input int bl, input int l, input rec_t e);
    burst_len  = 16'(b);
    damp_len   = 16'(d);
    blank_len  = 16'(bl);
    listen_len = 16'(l);
    start      = 1'b1;
    start_acc  = 1'b1;
    sb.push_back(e);
    cyc(1);
    start      = 1'b0;
    start_acc  = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int k;
    k = 0;
    while (sb.size() != 0 && k < budget) begin
      cyc(1);
      k++;
    end
    if (sb.size() != 0) begin
      check("timeout", 0, 1);
      sb.delete();
      mon_active = 1'b0;
    end
    cyc(2);
  endtask

  initial begin
    // Reset state
    cyc(3);
    check("rst_hb",      int'(hb_state), int'(HB_HIGHZ));
    check("rst_busy",    int'(busy),     0);
    check("rst_rx_en",   int'(rx_en),    0);
    check("rst_done",    int'(done),     0);
    check("rst_aborted", int'(aborted),  0);
    rst = 1'b1;
    cyc(2);

    // Normal ping
    issue_start(4, 10, 20, 100, exp_normal(4, 10, 20, 100));
    wait_end(1000);

    // Abort during TX at cycle 100
    issue_start(8, 5, 20, 100, exp_abort_tx(5, 100));
    cyc(99);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    wait_end(1000);

    // Abort during TX with no damping time: straight to IDLE
    issue_start(2, 0, 5, 5, exp_abort_tx(0, 10));
    cyc(9);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    wait_end(500);

    // Abort during DAMP (cycles 65..84): damping still completes
    issue_start(1, 20, 5, 5, '{64, 1, 20, 65, 0, 0, 84, 85, 2});
    cyc(69);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    wait_end(500);

    // Abort during LISTEN (starts at 70), abort seen in cycle 80
    issue_start(1, 2, 3, 50, '{64, 1, 2, 65, 11, 70, 80, 81, 2});
    cyc(79);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    wait_end(500);

    // Zero damp and blank: TX runs straight into LISTEN
    issue_start(2, 0, 0, 30, exp_normal(2, 0, 0, 30));
    wait_end(500);

    // All lengths zero: done one cycle later, never busy
    issue_start(0, 0, 0, 0, exp_normal(0, 0, 0, 0));
    wait_end(50);

    // Skipped TX: damping only
    issue_start(0, 7, 0, 3, exp_normal(0, 7, 0, 3));
    wait_end(100);

    // Second start mid-ping with new lengths is ignored
    issue_start(4, 10, 20, 100, exp_normal(4, 10, 20, 100));
    cyc(49);
    start      = 1'b1;
    burst_len  = 16'd1;
    damp_len   = 16'd1;
    blank_len  = 16'd1;
    listen_len = 16'd1;
    cyc(1);
    start = 1'b0;
    wait_end(1000);

    // Back-to-back: new start in the done cycle (141)
    issue_start(2, 3, 4, 5, exp_normal(2, 3, 4, 5));
    cyc(140);
    issue_start(1, 2, 2, 2, exp_normal(1, 2, 2, 2));
    wait_end(500);

    // Abort in IDLE has no effect
    abort = 1'b1;
    cyc(3);
    check("idle_abort_busy", int'(busy), 0);
    abort = 1'b0;

    // start and abort together in IDLE: abort wins
    burst_len  = 16'd2;
    damp_len   = 16'd2;
    blank_len  = 16'd2;
    listen_len = 16'd2;
    start = 1'b1;
    abort = 1'b1;
    cyc(1);
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", int'(busy), 0);
    check("start_abort_hb",   int'(hb_state), int'(HB_HIGHZ));
    cyc(3);
    check("start_abort_busy_later", int'(busy), 0);

    // Reset mid-TX: everything back to reset values on the next edge
    issue_start(4, 10, 20, 100, exp_normal(4, 10, 20, 100));
    cyc(99);
    check("pre_rst_hb", int'(hb_state), int'(HB_OSCL));
    rst  = 1'b0;
    kill = 1'b1;
    cyc(1);
    check("midrst_hb",      int'(hb_state), int'(HB_HIGHZ));
    check("midrst_busy",    int'(busy),     0);
    check("midrst_rx_en",   int'(rx_en),    0);
    check("midrst_done",    int'(done),     0);
    check("midrst_aborted", int'(aborted),  0);
    kill = 1'b0;
    rst  = 1'b1;
    cyc(3);
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_hb",   int'(hb_state), int'(HB_HIGHZ));

    // Ping after reset behaves normally
    issue_start(1, 1, 1, 1, exp_normal(1, 1, 1, 1));
    wait_end(200);

    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
